// File: rtl/ct_ifu_addrgen_pkg.sv
// Shared defaults and the BTB training record for the IFU address generator.
package ct_ifu_addrgen_pkg;

    localparam int AG_PC_WIDTH     = 40;
    localparam int AG_NUM_BR       = 2;
    localparam int AG_OFFSET_WIDTH = 21;
    localparam int AG_UPQ_DEPTH    = 4;
    localparam int AG_BTB_IDX_W    = 10;
    localparam int AG_BTB_TAG_W    = 10;
    localparam int AG_BTB_TGT_W    = 20;
    localparam int AG_L0_ENTRIES   = 16;

    typedef struct packed {
        logic [AG_BTB_IDX_W-1:0] idx;
        logic [AG_BTB_TAG_W-1:0] tag;
        logic [AG_BTB_TGT_W-1:0] tgt;
    } btb_upd_t;

    localparam int AG_UPD_W = $bits(btb_upd_t);

endpackage

// File: rtl/ct_ifu_addrgen_upq.sv
// Small synchronous FIFO holding resolved BTB training writes.
module ct_ifu_addrgen_upq
    import ct_ifu_addrgen_pkg::*;
#(
    parameter int WIDTH = AG_UPD_W,
    parameter int DEPTH = AG_UPQ_DEPTH
) (
    input  logic             addrgen_flop_clk,
    input  logic             cpurst_b,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot for a push into a full queue.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign head    = mem[rd_ptr];

    always_ff @(posedge addrgen_flop_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CW'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ct_ifu_addrgen_mc.sv
// IB-stage direct-branch target checker: redirects PC to the oldest
// mispredicted branch and queues BTB training writes.
module ct_ifu_addrgen_mc
    import ct_ifu_addrgen_pkg::*;
#(
    parameter int PC_WIDTH     = AG_PC_WIDTH,
    parameter int NUM_BR       = AG_NUM_BR,
    parameter int OFFSET_WIDTH = AG_OFFSET_WIDTH,
    parameter int UPQ_DEPTH    = AG_UPQ_DEPTH,
    parameter int BTB_IDX_W    = AG_BTB_IDX_W,
    parameter int BTB_TAG_W    = AG_BTB_TAG_W,
    parameter int BTB_TGT_W    = AG_BTB_TGT_W,
    parameter int L0_ENTRIES   = AG_L0_ENTRIES
) (
    input  logic                             addrgen_flop_clk,
    input  logic                             cpurst_b,
    output logic                             addrgen_flop_clk_en,
    input  logic [NUM_BR-1:0]                ibdp_addrgen_br_vld,
    input  logic [NUM_BR*(PC_WIDTH-1)-1:0]   ibdp_addrgen_br_base,
    input  logic [NUM_BR*OFFSET_WIDTH-1:0]   ibdp_addrgen_br_offset,
    input  logic [NUM_BR*(PC_WIDTH-1)-1:0]   ibdp_addrgen_br_result,
    input  logic [NUM_BR*(PC_WIDTH-1)-1:0]   ibdp_addrgen_btb_index_pc,
    input  logic [NUM_BR-1:0]                ibdp_addrgen_l0_btb_hit,
    input  logic [NUM_BR*L0_ENTRIES-1:0]     ibdp_addrgen_l0_btb_hit_entry,
    input  logic [7:0]                       ibdp_addrgen_vl,
    input  logic [1:0]                       ibdp_addrgen_vlmul,
    input  logic [2:0]                       ibdp_addrgen_vsew,
    input  logic                             lbuf_addrgen_active_state,
    input  logic                             lbuf_addrgen_cache_state,
    input  logic                             lbuf_addrgen_chgflw_mask,
    input  logic                             pcgen_addrgen_cancel,
    input  logic                             btb_addrgen_upd_rdy,
    output logic                             addrgen_pcgen_pcload,
    output logic                             addrgen_xx_pcload,
    output logic                             addrgen_ibctrl_cancel,
    output logic [PC_WIDTH-2:0]              addrgen_pcgen_pc,
    output logic [7:0]                       addrgen_ipdp_chgflw_vl,
    output logic [1:0]                       addrgen_ipdp_chgflw_vlmul,
    output logic [2:0]                       addrgen_ipdp_chgflw_vsew,
    output logic                             addrgen_btb_update_vld,
    output logic [BTB_IDX_W-1:0]             addrgen_btb_index,
    output logic [BTB_TAG_W-1:0]             addrgen_btb_tag,
    output logic [BTB_TGT_W-1:0]             addrgen_btb_target_pc,
    output logic                             addrgen_l0_btb_update_vld,
    output logic [3:0]                       addrgen_l0_btb_wen,
    output logic                             addrgen_l0_btb_update_vld_bit,
    output logic [L0_ENTRIES-1:0]            addrgen_l0_btb_update_entry,
    output logic [$clog2(NUM_BR+1)-1:0]      ifu_hpcp_btb_inst_cnt,
    output logic                             ifu_hpcp_btb_mispred,
    output logic                             ifu_hpcp_btb_upd_drop
);

    localparam int PCW  = PC_WIDTH - 1;
    localparam int OW   = OFFSET_WIDTH;
    localparam int SXW  = PCW - (OW - 1);
    localparam int CNTW = $clog2(NUM_BR + 1);
    localparam int SELW = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;

    logic [PCW-1:0]        base_s [NUM_BR];
    logic [PCW-1:0]        res_s  [NUM_BR];
    logic [PCW-1:0]        idx_s  [NUM_BR];
    logic [PCW-1:0]        cal_s  [NUM_BR];
    logic [OW-1:0]         off_s  [NUM_BR];
    logic [L0_ENTRIES-1:0] ent_s  [NUM_BR];
    logic [NUM_BR-1:0]     qv;
    logic [NUM_BR-1:0]     mis;
    logic [NUM_BR-1:0]     off_lsb_unused;

    logic                  vld_q;
    logic                  mis_q;
    logic [PCW-1:0]        cal_q;
    logic [BTB_IDX_W-1:0]  index_q;
    logic [BTB_TAG_W-1:0]  tag_q;
    logic                  l0_hit_q;
    logic [L0_ENTRIES-1:0] l0_entry_q;
    logic [7:0]            vl_q;
    logic [1:0]            vlmul_q;
    logic [2:0]            vsew_q;
    logic [CNTW-1:0]       cnt_q;

    logic                  pcload_now;
    logic                  any_qv;
    logic                  win_vld;
    logic [SELW-1:0]       win_sel;
    logic [CNTW-1:0]       win_cnt;
    logic [PCW-1:0]        idx_win;
    logic                  idx_hi_unused;

    btb_upd_t              upd_push;
    btb_upd_t              upd_head;
    logic                  upq_full;
    logic                  upq_empty;

    assign pcload_now = vld_q & mis_q;

    for (genvar g = 0; g < NUM_BR; g++) begin : g_slot
        assign base_s[g] = ibdp_addrgen_br_base[g*PCW +: PCW];
        assign res_s[g]  = ibdp_addrgen_br_result[g*PCW +: PCW];
        assign idx_s[g]  = ibdp_addrgen_btb_index_pc[g*PCW +: PCW];
        assign off_s[g]  = ibdp_addrgen_br_offset[g*OW +: OW];
        assign ent_s[g]  = ibdp_addrgen_l0_btb_hit_entry[g*L0_ENTRIES +: L0_ENTRIES];
        assign cal_s[g]  = base_s[g] + {{SXW{off_s[g][OW-1]}}, off_s[g][OW-1:1]};
        assign mis[g]    = (res_s[g] != cal_s[g]);
        assign off_lsb_unused[g] = off_s[g][0];
        // Anything in IB while a redirect is leaving is wrong-path.
        assign qv[g] = ibdp_addrgen_br_vld[g] & ~lbuf_addrgen_active_state
                     & ~lbuf_addrgen_cache_state & ~lbuf_addrgen_chgflw_mask
                     & ~pcload_now;
    end

    assign any_qv = |qv;

    always_comb begin
        win_vld = 1'b0;
        win_sel = '0;
        win_cnt = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            if (qv[i] && !win_vld) begin
                win_cnt = win_cnt + CNTW'(1);
                if (mis[i]) begin
                    win_vld = 1'b1;
                    win_sel = SELW'(i);
                end
            end
        end
    end

    assign idx_win       = idx_s[win_sel];
    assign idx_hi_unused = ^{idx_win[PCW-1:20], off_lsb_unused};

    always_ff @(posedge addrgen_flop_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            vld_q <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            vld_q <= any_qv & ~pcgen_addrgen_cancel;
            if (any_qv) begin
                mis_q <= win_vld;
            end
        end
    end

    always_ff @(posedge addrgen_flop_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cal_q      <= '0;
            index_q    <= '0;
            tag_q      <= '0;
            l0_hit_q   <= 1'b0;
            l0_entry_q <= '0;
            vl_q       <= '0;
            vlmul_q    <= '0;
            vsew_q     <= '0;
            cnt_q      <= '0;
        end else if (any_qv) begin
            cal_q      <= cal_s[win_sel];
            index_q    <= idx_win[12:3];
            tag_q      <= {idx_win[19:13], idx_win[2:0]};
            l0_hit_q   <= ibdp_addrgen_l0_btb_hit[win_sel];
            l0_entry_q <= ent_s[win_sel];
            vl_q       <= ibdp_addrgen_vl;
            vlmul_q    <= ibdp_addrgen_vlmul;
            vsew_q     <= ibdp_addrgen_vsew;
            cnt_q      <= win_cnt;
        end
    end

    assign addrgen_pcgen_pcload      = pcload_now;
    assign addrgen_xx_pcload         = pcload_now;
    assign addrgen_ibctrl_cancel     = pcload_now;
    assign ifu_hpcp_btb_mispred      = pcload_now;
    assign addrgen_pcgen_pc          = cal_q;
    assign addrgen_ipdp_chgflw_vl    = vl_q;
    assign addrgen_ipdp_chgflw_vlmul = vlmul_q;
    assign addrgen_ipdp_chgflw_vsew  = vsew_q;
    assign ifu_hpcp_btb_inst_cnt     = vld_q ? cnt_q : '0;

    assign addrgen_l0_btb_update_vld     = pcload_now & l0_hit_q;
    assign addrgen_l0_btb_wen            = {addrgen_l0_btb_update_vld, 3'b000};
    assign addrgen_l0_btb_update_vld_bit = 1'b0;
    assign addrgen_l0_btb_update_entry   = l0_entry_q;

    assign upd_push.idx = index_q;
    assign upd_push.tag = tag_q;
    assign upd_push.tgt = cal_q[BTB_TGT_W-1:0];

    ct_ifu_addrgen_upq #(
        .WIDTH (AG_UPD_W),
        .DEPTH (UPQ_DEPTH)
    ) u_upq (
        .addrgen_flop_clk (addrgen_flop_clk),
        .cpurst_b         (cpurst_b),
        .push             (pcload_now),
        .push_data        (upd_push),
        .pop              (btb_addrgen_upd_rdy),
        .head             (upd_head),
        .full             (upq_full),
        .empty            (upq_empty),
        .drop             (ifu_hpcp_btb_upd_drop)
    );

    assign addrgen_btb_update_vld = ~upq_empty;
    assign addrgen_btb_index      = upd_head.idx;
    assign addrgen_btb_tag        = upd_head.tag;
    assign addrgen_btb_target_pc  = upd_head.tgt;

    assign addrgen_flop_clk_en = (|(ibdp_addrgen_br_vld
                                    & ~{NUM_BR{lbuf_addrgen_active_state}}
                                    & ~{NUM_BR{lbuf_addrgen_cache_state}}))
                               | vld_q | pcgen_addrgen_cancel
                               | ~upq_empty | pcload_now;

    logic upq_full_unused;
    assign upq_full_unused = upq_full & idx_hi_unused;

endmodule

// File: tb/tb_ct_ifu_addrgen_mc.sv
// Randomised and directed bench for ct_ifu_addrgen_mc with a behavioural model.
module tb_ct_ifu_addrgen_mc;

    localparam int PCW   = 39;
    localparam int NB    = 2;
    localparam int OW    = 21;
    localparam int LE    = 16;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              clk_en;
    logic [NB-1:0]     br_vld;
    logic [NB*PCW-1:0] br_base;
    logic [NB*OW-1:0]  br_offset;
    logic [NB*PCW-1:0] br_result;
    logic [NB*PCW-1:0] idx_pc;
    logic [NB-1:0]     l0_hit;
    logic [NB*LE-1:0]  l0_entry;
    logic [7:0]        vl;
    logic [1:0]        vlmul;
    logic [2:0]        vsew;
    logic              active, cache, mask, cancel, upd_rdy;
    logic              pcload, xx_pcload, ib_cancel;
    logic [PCW-1:0]    pc;
    logic [7:0]        o_vl;
    logic [1:0]        o_vlmul;
    logic [2:0]        o_vsew;
    logic              upd_vld;
    logic [9:0]        upd_idx, upd_tag;
    logic [19:0]       upd_tgt;
    logic              l0_vld, l0_vld_bit;
    logic [3:0]        l0_wen;
    logic [LE-1:0]     l0_upd_entry;
    logic [1:0]        inst_cnt;
    logic              mispred, upd_drop;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ct_ifu_addrgen_mc dut (
        .addrgen_flop_clk              (clk),
        .cpurst_b                      (rst_b),
        .addrgen_flop_clk_en           (clk_en),
        .ibdp_addrgen_br_vld           (br_vld),
        .ibdp_addrgen_br_base          (br_base),
        .ibdp_addrgen_br_offset        (br_offset),
        .ibdp_addrgen_br_result        (br_result),
        .ibdp_addrgen_btb_index_pc     (idx_pc),
        .ibdp_addrgen_l0_btb_hit       (l0_hit),
        .ibdp_addrgen_l0_btb_hit_entry (l0_entry),
        .ibdp_addrgen_vl               (vl),
        .ibdp_addrgen_vlmul            (vlmul),
        .ibdp_addrgen_vsew             (vsew),
        .lbuf_addrgen_active_state     (active),
        .lbuf_addrgen_cache_state      (cache),
        .lbuf_addrgen_chgflw_mask      (mask),
        .pcgen_addrgen_cancel          (cancel),
        .btb_addrgen_upd_rdy           (upd_rdy),
        .addrgen_pcgen_pcload          (pcload),
        .addrgen_xx_pcload             (xx_pcload),
        .addrgen_ibctrl_cancel         (ib_cancel),
        .addrgen_pcgen_pc              (pc),
        .addrgen_ipdp_chgflw_vl        (o_vl),
        .addrgen_ipdp_chgflw_vlmul     (o_vlmul),
        .addrgen_ipdp_chgflw_vsew      (o_vsew),
        .addrgen_btb_update_vld        (upd_vld),
        .addrgen_btb_index             (upd_idx),
        .addrgen_btb_tag               (upd_tag),
        .addrgen_btb_target_pc         (upd_tgt),
        .addrgen_l0_btb_update_vld     (l0_vld),
        .addrgen_l0_btb_wen            (l0_wen),
        .addrgen_l0_btb_update_vld_bit (l0_vld_bit),
        .addrgen_l0_btb_update_entry   (l0_upd_entry),
        .ifu_hpcp_btb_inst_cnt         (inst_cnt),
        .ifu_hpcp_btb_mispred          (mispred),
        .ifu_hpcp_btb_upd_drop         (upd_drop)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Target = base + (signed offset field above bit 0), wrapped to 39 bits.
    function automatic logic [PCW-1:0] cal_of(input logic [PCW-1:0] b, input logic [OW-1:0] o);
        longint off;
        longint sum;
        off = longint'(o[OW-1:1]);
        if (o[OW-1]) off = off - (longint'(1) << (OW - 1));
        sum = longint'(b) + off;
        return PCW'(sum & ((longint'(1) << PCW) - 1));
    endfunction

    // Model of what is "in flight" after each clock edge.
    bit             m_vld, m_mis, m_l0hit;
    logic [PCW-1:0] m_pc;
    int             m_cnt;
    logic [LE-1:0]  m_ent;
    logic [7:0]     m_vl;
    logic [1:0]     m_vlmul;
    logic [2:0]     m_vsew;
    logic [9:0]     m_idx, m_tag;
    logic [39:0]    m_q[$];

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_vld = 0; m_mis = 0; m_l0hit = 0; m_pc = '0; m_cnt = 0;
            m_ent = '0; m_vl = '0; m_vlmul = '0; m_vsew = '0;
            m_idx = '0; m_tag = '0;
            m_q.delete();
        end else begin
            bit pl, anyq, found, q;
            int n, w;
            logic [PCW-1:0] ip;
            pl = m_vld && m_mis;
            if (m_q.size() > 0 && upd_rdy) void'(m_q.pop_front());
            if (pl && m_q.size() < DEPTH) m_q.push_back({m_idx, m_tag, m_pc[19:0]});
            anyq = 0; found = 0; n = 0; w = 0;
            for (int i = 0; i < NB; i++) begin
                q = br_vld[i] && !active && !cache && !mask && !pl;
                anyq |= q;
                if (q && !found) begin
                    n++;
                    if (cal_of(br_base[i*PCW +: PCW], br_offset[i*OW +: OW])
                        != br_result[i*PCW +: PCW]) begin
                        found = 1;
                        w = i;
                    end
                end
            end
            m_vld = anyq && !cancel;
            if (anyq) begin
                m_mis   = found;
                m_cnt   = n;
                m_pc    = cal_of(br_base[w*PCW +: PCW], br_offset[w*OW +: OW]);
                ip      = idx_pc[w*PCW +: PCW];
                m_idx   = ip[12:3];
                m_tag   = {ip[19:13], ip[2:0]};
                m_l0hit = l0_hit[w];
                m_ent   = l0_entry[w*LE +: LE];
                m_vl    = vl;
                m_vlmul = vlmul;
                m_vsew  = vsew;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit pl;
            logic [39:0] e;
            pl = m_vld && m_mis;
            chk("pcload", pcload, pl);
            chk("xx_pcload", xx_pcload, pl);
            chk("ib_cancel", ib_cancel, pl);
            chk("mispred", mispred, pl);
            if (pl) begin
                chk("pc", pc, m_pc);
                chk("vl", o_vl, m_vl);
                chk("vlmul", o_vlmul, m_vlmul);
                chk("vsew", o_vsew, m_vsew);
            end
            chk("l0_vld", l0_vld, pl && m_l0hit);
            chk("l0_wen", l0_wen, (pl && m_l0hit) ? 4'b1000 : 4'b0000);
            chk("l0_vld_bit", l0_vld_bit, 0);
            if (pl && m_l0hit) chk("l0_entry", l0_upd_entry, m_ent);
            chk("inst_cnt", inst_cnt, m_vld ? m_cnt : 0);
            chk("upd_vld", upd_vld, m_q.size() > 0);
            if (m_q.size() > 0) begin
                e = m_q[0];
                chk("upd_idx", upd_idx, e[39:30]);
                chk("upd_tag", upd_tag, e[29:20]);
                chk("upd_tgt", upd_tgt, e[19:0]);
            end
            chk("upd_drop", upd_drop, pl && m_q.size() == DEPTH && !upd_rdy);
            chk("clk_en", clk_en, ((br_vld & ~{NB{active}} & ~{NB{cache}}) != 0)
                                  || m_vld || cancel || m_q.size() > 0 || pl);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        br_vld = '0; cancel = 0; active = 0; cache = 0; mask = 0;
        l0_hit = '0;
    endtask

    task automatic set_slot(input int i, input logic [PCW-1:0] b, input logic [OW-1:0] o,
                            input logic [PCW-1:0] r, input logic [PCW-1:0] ip,
                            input logic h, input logic [LE-1:0] en);
        br_base[i*PCW +: PCW]   = b;
        br_offset[i*OW +: OW]   = o;
        br_result[i*PCW +: PCW] = r;
        idx_pc[i*PCW +: PCW]    = ip;
        l0_hit[i]               = h;
        l0_entry[i*LE +: LE]    = en;
    endtask

    initial begin
        logic [PCW-1:0] b, ip;
        logic [OW-1:0]  o;
        br_base = '0; br_offset = '0; br_result = '0; idx_pc = '0;
        l0_entry = '0; vl = '0; vlmul = '0; vsew = '0;
        idle();
        upd_rdy = 1;
        chk_en  = 1;
        repeat (3) step();
        chk("rst_pcload", pcload, 0);
        chk("rst_pc", pc, 0);
        chk("rst_upd_vld", upd_vld, 0);
        rst_b = 1;
        step();

        // Correctly predicted single branch.
        set_slot(0, 39'h1000, 21'h40, 39'h1020, 39'h0, 0, '0);
        br_vld = 2'b01;
        step();
        chk("t1_pcload", pcload, 0);
        chk("t1_cnt", inst_cnt, 1);
        chk("t1_empty", upd_vld, 0);
        idle();
        step();

        // Slot 1 mispredicts with a negative offset.
        set_slot(0, 39'h1000, 21'h40, 39'h1020, 39'h0, 0, '0);
        set_slot(1, 39'h2000, 21'h1FFFFC, 39'h2100, 39'hABCD8, 0, '0);
        br_vld = 2'b11; vl = 8'h12; vlmul = 2'd2; vsew = 3'd5;
        step();
        chk("t2_pcload", pcload, 1);
        chk("t2_pc", pc, 39'h1FFE);
        chk("t2_cnt", inst_cnt, 2);
        idle();
        step();
        chk("t2_upd_vld", upd_vld, 1);
        chk("t2_upd_tgt", upd_tgt, 20'h01FFE);
        step();

        // Both mispredict: slot 0 wins; the next cycle is killed.
        set_slot(0, 39'h1000, 21'h40, 39'h5555, 39'h0, 0, '0);
        set_slot(1, 39'h2000, 21'h1FFFFC, 39'h0, 39'h0, 0, '0);
        br_vld = 2'b11;
        step();
        chk("t3_pcload", pcload, 1);
        chk("t3_pc", pc, 39'h1020);
        chk("t3_cnt", inst_cnt, 1);
        step();
        chk("t3_kill", pcload, 0);
        idle();
        step();
        step();

        // Fill the update queue while the BTB is busy.
        upd_rdy = 0;
        for (int k = 0; k < 5; k++) begin
            set_slot(0, 39'h3000 + 39'(k * 'h100), 21'h40, 39'h0, 39'h0, 0, '0);
            br_vld = 2'b01;
            step();
            chk("t4_pcload", pcload, 1);
            chk("t4_drop", upd_drop, k == 4);
            idle();
            step();
        end
        chk("t4_full", upd_vld, 1);
        upd_rdy = 1;
        for (int j = 0; j < 4; j++) begin
            chk("t4_drain_vld", upd_vld, 1);
            chk("t4_drain_tgt", upd_tgt, 20'h3020 + 20'(j * 'h100));
            step();
        end
        chk("t4_drained", upd_vld, 0);

        // Cancel kills a mispredict; then an L0-hit mispredict.
        set_slot(0, 39'h1000, 21'h40, 39'h0, 39'h0, 0, '0);
        br_vld = 2'b01; cancel = 1;
        step();
        chk("t5_cancel", pcload, 0);
        idle();
        step();
        set_slot(0, 39'h4000, 21'h40, 39'h0, 39'h0, 1, 16'h0008);
        br_vld = 2'b01;
        step();
        chk("t5_l0_vld", l0_vld, 1);
        chk("t5_l0_wen", l0_wen, 4'b1000);
        chk("t5_l0_entry", l0_upd_entry, 16'h0008);
        idle();
        step();
        step();

        // Loop buffer in cache state masks the branch and the clock enable.
        set_slot(0, 39'h1000, 21'h40, 39'h0, 39'h0, 0, '0);
        br_vld = 2'b01; cache = 1;
        step();
        chk("t6_pcload", pcload, 0);
        chk("t6_clk_en", clk_en, 0);
        idle();
        step();

        // Asynchronous reset with a queued entry and a pending redirect.
        upd_rdy = 0;
        set_slot(0, 39'h5000, 21'h40, 39'h0, 39'h0, 0, '0);
        br_vld = 2'b01;
        step();
        idle();
        step();
        br_vld = 2'b01;
        step();
        chk("t7_pre_pcload", pcload, 1);
        #2 rst_b = 0;
        #1;
        chk("t7_rst_pcload", pcload, 0);
        chk("t7_rst_pc", pc, 0);
        chk("t7_rst_upd_vld", upd_vld, 0);
        idle();
        step();
        step();
        rst_b = 1;
        step();
        chk("t7_lost", upd_vld, 0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NB; i++) begin
                b  = {$urandom, $urandom};
                o  = OW'($urandom);
                ip = {$urandom, $urandom};
                set_slot(i, b, o, ($urandom_range(0, 1) == 0) ? cal_of(b, o) : {$urandom, $urandom},
                         ip, 1'($urandom), LE'(1) << $urandom_range(0, LE - 1));
            end
            br_vld  = NB'($urandom);
            vl      = 8'($urandom);
            vlmul   = 2'($urandom);
            vsew    = 3'($urandom);
            cancel  = ($urandom_range(0, 19) == 0);
            active  = ($urandom_range(0, 9) == 0);
            cache   = ($urandom_range(0, 9) == 0);
            mask    = ($urandom_range(0, 9) == 0);
            upd_rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        upd_rdy = 1;
        repeat (8) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
